// File: rtl/pll_lock_sequencer_if.sv
// Signal bundle between the PLL lock sequencer and the PLL / system-reset logic.
// The sequencer uses the master modport; the PLL and system side use the slave modport.
interface pll_lock_sequencer_if;
    logic       pll_locked;
    logic       restart;
    logic       pll_resetb;
    logic       pll_bypass;
    logic       sys_ready;
    logic       fail;
    logic       lock_lost;
    logic [3:0] retry_cnt;
    logic [3:0] lost_cnt;
    logic [2:0] state;

    modport master (
        input  pll_locked, restart,
        output pll_resetb, pll_bypass, sys_ready, fail, lock_lost,
               retry_cnt, lost_cnt, state
    );

    modport slave (
        output pll_locked, restart,
        input  pll_resetb, pll_bypass, sys_ready, fail, lock_lost,
               retry_cnt, lost_cnt, state
    );
endinterface

// File: rtl/pll_lock_sequencer.sv
// Reference-clock-domain sequencer: resets the PLL, qualifies its lock and releases sys_ready.
// It re-acquires the PLL on lock loss and falls back to PLL bypass after repeated failures.
module pll_lock_sequencer #(
    parameter int PLL_RST_CYCLES = 16,
    parameter int LOCK_TIMEOUT   = 65536,
    parameter int STABLE_CYCLES  = 1024,
    parameter int MAX_RETRIES    = 4
) (
    input  logic                clock,
    input  logic                reset_n,
    pll_lock_sequencer_if.master bus
);
    localparam int CNT_MAX_A = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
    localparam int CNT_MAX   = (CNT_MAX_A > STABLE_CYCLES) ? CNT_MAX_A : STABLE_CYCLES;
    localparam int CNT_W     = $clog2(CNT_MAX);

    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);

    typedef enum logic [2:0] {
        RESET_PLL = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RUN       = 3'd3,
        FAIL      = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sync1_q, lock_s;
    logic [3:0]       retry_q, retry_d;
    logic [3:0]       lost_q, lost_d;
    logic             lock_lost_d, lock_lost_q;
    logic             pll_resetb_q, pll_bypass_q, sys_ready_q, fail_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= RESET_PLL;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        retry_d     = retry_q;
        lost_d      = lost_q;
        lock_lost_d = 1'b0;
        if (bus.restart) begin
            state_d = RESET_PLL;
            retry_d = '0;
        end else begin
            case (state_q)
                RESET_PLL: if (cnt_q == RST_LAST) state_d = WAIT_LOCK;
                WAIT_LOCK: begin
                    // Lock arriving on the timeout cycle wins over the retry.
                    if (lock_s) begin
                        state_d = STABLE;
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        retry_d = retry_q + 4'd1;
                        state_d = (retry_d == 4'(MAX_RETRIES)) ? FAIL : RESET_PLL;
                    end
                end
                STABLE: begin
                    if (!lock_s) begin
                        state_d = WAIT_LOCK;
                    end else if (cnt_q == STABLE_LAST) begin
                        state_d = RUN;
                        retry_d = '0;
                    end
                end
                RUN: begin
                    retry_d = '0;
                    if (!lock_s) begin
                        state_d     = RESET_PLL;
                        lock_lost_d = 1'b1;
                        if (lost_q != 4'hF) lost_d = lost_q + 4'd1;
                    end
                end
                FAIL:    state_d = FAIL;
                default: state_d = RESET_PLL;
            endcase
        end
        cnt_d = (bus.restart || (state_d != state_q)) ? '0 : cnt_q + 1'b1;
    end

    // Outputs are registered from the next state so they change on the transition edge.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q      <= 1'b0;
            lock_s       <= 1'b0;
            cnt_q        <= '0;
            retry_q      <= '0;
            lost_q       <= '0;
            lock_lost_q  <= 1'b0;
            pll_resetb_q <= 1'b0;
            pll_bypass_q <= 1'b0;
            sys_ready_q  <= 1'b0;
            fail_q       <= 1'b0;
        end else begin
            sync1_q      <= bus.pll_locked;
            lock_s       <= sync1_q;
            cnt_q        <= cnt_d;
            retry_q      <= retry_d;
            lost_q       <= lost_d;
            lock_lost_q  <= lock_lost_d;
            pll_resetb_q <= (state_d == WAIT_LOCK) || (state_d == STABLE) || (state_d == RUN);
            pll_bypass_q <= (state_d == FAIL);
            sys_ready_q  <= (state_d == RUN) || (state_d == FAIL);
            fail_q       <= (state_d == FAIL);
        end
    end

    assign bus.pll_resetb = pll_resetb_q;
    assign bus.pll_bypass = pll_bypass_q;
    assign bus.sys_ready  = sys_ready_q;
    assign bus.fail       = fail_q;
    assign bus.lock_lost  = lock_lost_q;
    assign bus.retry_cnt  = retry_q;
    assign bus.lost_cnt   = lost_q;
    assign bus.state      = state_q;
endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed bench for pll_lock_sequencer with short timing parameters (4/32/8/3).
// Expected values are hand-computed edge counts from the sequencing rules.
module tb_pll_lock_sequencer;
    logic clock;
    logic reset_n;
    int   total  = 0;
    int   passed = 0;
    int   errors = 0;

    pll_lock_sequencer_if bus ();

    pll_lock_sequencer #(
        .PLL_RST_CYCLES(4),
        .LOCK_TIMEOUT  (32),
        .STABLE_CYCLES (8),
        .MAX_RETRIES   (3)
    ) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_state(input logic [2:0] s, input int budget, input string tag);
        for (int i = 0; i < budget; i++) begin
            if (bus.state == s) break;
            tick(1);
        end
        check(tag, 32'(bus.state), 32'(s));
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_state"},      32'(bus.state),      0);
        check({tag, "_pll_resetb"}, 32'(bus.pll_resetb), 0);
        check({tag, "_pll_bypass"}, 32'(bus.pll_bypass), 0);
        check({tag, "_sys_ready"},  32'(bus.sys_ready),  0);
        check({tag, "_fail"},       32'(bus.fail),       0);
        check({tag, "_lock_lost"},  32'(bus.lock_lost),  0);
        check({tag, "_retry_cnt"},  32'(bus.retry_cnt),  0);
        check({tag, "_lost_cnt"},   32'(bus.lost_cnt),   0);
    endtask

    initial begin
        bus.pll_locked = 1'b0;
        bus.restart    = 1'b0;
        reset_n        = 1'b1;
        #1 reset_n = 1'b0;
        #1 check_reset_values("rst");

        // 1. Normal lock
        @(negedge clock);
        reset_n = 1'b1;
        tick(3);
        check("rstpll_hold_resetb", 32'(bus.pll_resetb), 0);
        check("rstpll_hold_state",  32'(bus.state),      0);
        tick(1);
        check("rstpll_rel_resetb", 32'(bus.pll_resetb), 1);
        check("rstpll_rel_state",  32'(bus.state),      1);
        tick(6);
        bus.pll_locked = 1'b1;
        tick(2);
        check("sync_delay_state", 32'(bus.state), 1);
        tick(1);
        check("enter_stable", 32'(bus.state), 2);
        tick(7);
        check("stable_ready_low", 32'(bus.sys_ready), 0);
        check("stable_state",     32'(bus.state),     2);
        tick(1);
        check("run_ready",  32'(bus.sys_ready),  1);
        check("run_state",  32'(bus.state),      3);
        check("run_retry",  32'(bus.retry_cnt),  0);
        check("run_bypass", 32'(bus.pll_bypass), 0);

        // 3. Lock loss, single-cycle drop
        bus.pll_locked = 1'b0;
        tick(1);
        bus.pll_locked = 1'b1;
        tick(1);
        check("loss_pre_state", 32'(bus.state),     3);
        check("loss_pre_ready", 32'(bus.sys_ready), 1);
        tick(1);
        check("loss_state",     32'(bus.state),      0);
        check("loss_ready",     32'(bus.sys_ready),  0);
        check("loss_pulse",     32'(bus.lock_lost),  1);
        check("loss_cnt",       32'(bus.lost_cnt),   1);
        check("loss_resetb",    32'(bus.pll_resetb), 0);
        tick(1);
        check("loss_pulse_end", 32'(bus.lock_lost), 0);
        tick(11);
        check("relock_stable", 32'(bus.state), 2);
        tick(1);
        check("relock_run", 32'(bus.state), 3);

        // 5a. Restart in the cycle the FSM sees lock_s fall
        bus.pll_locked = 1'b0;
        tick(2);
        bus.restart = 1'b1;
        tick(1);
        bus.restart = 1'b0;
        check("rs_run_state",  32'(bus.state),      0);
        check("rs_run_pulse",  32'(bus.lock_lost),  0);
        check("rs_run_lost",   32'(bus.lost_cnt),   1);
        check("rs_run_ready",  32'(bus.sys_ready),  0);
        check("rs_run_fail",   32'(bus.fail),       0);
        check("rs_run_bypass", 32'(bus.pll_bypass), 0);

        // 2. Timeouts leading to FAIL (pll_locked stays low)
        tick(3);
        check("to_hold_resetb", 32'(bus.pll_resetb), 0);
        tick(1);
        check("to_wait_resetb", 32'(bus.pll_resetb), 1);
        check("to_wait_state",  32'(bus.state),      1);
        tick(31);
        check("to1_pre_state", 32'(bus.state),     1);
        check("to1_pre_retry", 32'(bus.retry_cnt), 0);
        tick(1);
        check("to1_state",  32'(bus.state),      0);
        check("to1_retry",  32'(bus.retry_cnt),  1);
        check("to1_resetb", 32'(bus.pll_resetb), 0);
        tick(36);
        check("to2_state", 32'(bus.state),     0);
        check("to2_retry", 32'(bus.retry_cnt), 2);
        tick(35);
        check("to3_pre_state", 32'(bus.state), 1);
        check("to3_pre_fail",  32'(bus.fail),  0);
        tick(1);
        check("fail_state",  32'(bus.state),      4);
        check("fail_flag",   32'(bus.fail),       1);
        check("fail_bypass", 32'(bus.pll_bypass), 1);
        check("fail_ready",  32'(bus.sys_ready),  1);
        check("fail_retry",  32'(bus.retry_cnt),  3);
        check("fail_resetb", 32'(bus.pll_resetb), 0);

        // FAIL ignores lock; 5b. restart leaves FAIL
        bus.pll_locked = 1'b1;
        tick(6);
        check("fail_sticky_state", 32'(bus.state), 4);
        check("fail_sticky_flag",  32'(bus.fail),  1);
        bus.restart = 1'b1;
        tick(1);
        bus.restart = 1'b0;
        check("rs_fail_state",  32'(bus.state),      0);
        check("rs_fail_fail",   32'(bus.fail),       0);
        check("rs_fail_bypass", 32'(bus.pll_bypass), 0);
        check("rs_fail_ready",  32'(bus.sys_ready),  0);
        check("rs_fail_retry",  32'(bus.retry_cnt),  0);
        check("rs_fail_lost",   32'(bus.lost_cnt),   1);
        wait_state(3'd3, 40, "rs_fail_relock");

        // 3b. Repeated lock losses saturate lost_cnt
        for (int k = 0; k < 20; k++) begin
            bus.pll_locked = 1'b0;
            tick(1);
            bus.pll_locked = 1'b1;
            wait_state(3'd0, 6, "rep_loss_state");
            check("rep_loss_pulse", 32'(bus.lock_lost), 1);
            tick(1);
            check("rep_loss_pulse_end", 32'(bus.lock_lost), 0);
            wait_state(3'd3, 30, "rep_relock");
        end
        check("lost_saturated", 32'(bus.lost_cnt), 15);

        // 4. Glitch in STABLE
        bus.pll_locked = 1'b0;
        tick(1);
        bus.pll_locked = 1'b1;
        wait_state(3'd2, 20, "gl_enter_stable");
        tick(5);
        bus.pll_locked = 1'b0;
        tick(1);
        bus.pll_locked = 1'b1;
        tick(1);
        check("gl_pre_state", 32'(bus.state), 2);
        tick(1);
        check("gl_back_wait", 32'(bus.state),     1);
        check("gl_retry",     32'(bus.retry_cnt), 0);
        check("gl_ready",     32'(bus.sys_ready), 0);
        tick(1);
        check("gl_restable", 32'(bus.state), 2);
        tick(7);
        check("gl_stable_hold", 32'(bus.state),     2);
        check("gl_ready_low",   32'(bus.sys_ready), 0);
        tick(1);
        check("gl_run",       32'(bus.state),     3);
        check("gl_run_ready", 32'(bus.sys_ready), 1);
        check("gl_lost_kept", 32'(bus.lost_cnt),  15);

        // 6. Async reset mid-WAIT_LOCK
        bus.pll_locked = 1'b0;
        bus.restart    = 1'b1;
        tick(1);
        bus.restart = 1'b0;
        check("pre_ar_state0", 32'(bus.state), 0);
        tick(4);
        check("pre_ar_wait", 32'(bus.state), 1);
        tick(3);
        #2 reset_n = 1'b0;
        #1 check_reset_values("async_rst");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/pll_lock_sequencer.md
Name: pll_lock_sequencer

Overview:
- Sequences the iCE40 PLL from the board reference clock: holds the PLL in reset, releases it, then waits for a stable lock.
- Qualifies the lock, then releases the system ready for the 6502 core and peripherals.
- Re-acquires the PLL on lock loss. After repeated lock failures it falls back to PLL bypass so the system still runs from the reference clock.
- Runs entirely in the reference-clock domain. The PLL output clock is not valid before lock.

Parameters:
PLL_RST_CYCLES, 16, cycles the PLL reset (active-low) is held low per attempt (>=2)
LOCK_TIMEOUT, 65536, cycles to wait in WAIT_LOCK before declaring an attempt failed (>=2)
STABLE_CYCLES, 1024, consecutive cycles lock must stay high before ready (>=2)
MAX_RETRIES, 4, failed attempts that trigger FAIL/bypass (1..15)
CNT_W, derived = $clog2 of max(PLL_RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES), shared phase counter width

Ports:
clock  in  1  reference clock (same net feeding the PLL reference input)
reset_n  in  1  asynchronous, active-low reset
pll_locked  in  1  raw PLL lock flag, asynchronous to clock
restart  in  1  synchronous one-cycle request to re-run the full sequence
pll_resetb  out  1  drives the PLL's active-low reset
pll_bypass  out  1  drives the PLL bypass input
sys_ready  out  1  system may leave reset; clock is valid
fail  out  1  sticky: MAX_RETRIES attempts failed, bypass active
lock_lost  out  1  one-cycle pulse when lock drops in RUN
retry_cnt  out  4  failed attempts since last RUN/restart
lost_cnt  out  4  lock-loss events, saturating at 15
state  out  3  FSM state for debug: 0 RESET_PLL, 1 WAIT_LOCK, 2 STABLE, 3 RUN, 4 FAIL

Behaviour:
- All outputs are registered.
- Reset (async assert, sync release) values:
  - state=RESET_PLL, counter=0.
  - pll_resetb=0, pll_bypass=0, sys_ready=0, fail=0, lock_lost=0.
  - retry_cnt=0, lost_cnt=0.
  - Synchronizer flops=0.
- pll_locked passes through a 2-flop synchronizer (lock_s). The FSM sees a change 2 edges after the first sampling edge.
- Counter clears on every state change and increments each cycle otherwise.
- RESET_PLL:
  - pll_resetb=0.
  - When counter==PLL_RST_CYCLES-1: go to WAIT_LOCK. pll_resetb=1 from that edge.
- WAIT_LOCK:
  - lock_s=1: go to STABLE.
  - Else, when counter==LOCK_TIMEOUT-1: retry_cnt+1. If the new value ==MAX_RETRIES, go to FAIL; else go to RESET_PLL.
- STABLE:
  - lock_s=0: go to WAIT_LOCK. This is a glitch during acquisition; retry_cnt is unchanged and the timeout restarts.
  - When counter==STABLE_CYCLES-1: go to RUN.
  - sys_ready rises on the same edge, exactly STABLE_CYCLES+2 edges after the first edge sampling pll_locked=1.
- RUN:
  - sys_ready=1. retry_cnt clears on entry.
  - lock_s=0: on the same edge go to RESET_PLL, sys_ready=0, pll_resetb=0, lock_lost=1 for one cycle, lost_cnt+1 (saturating).
- FAIL:
  - pll_resetb=0, pll_bypass=1, fail=1, sys_ready=1 (system runs from the reference clock).
  - pll_locked is ignored. Exit only via restart or reset_n.
- restart=1 in any state has priority over all lock and timeout events. Next state is RESET_PLL with:
  - counter=0, retry_cnt=0, fail=0, pll_bypass=0, sys_ready=0.
  - lost_cnt is kept.
  - A restart during RESET_PLL restarts the hold count.
- Simultaneous events:
  - Lock-loss and restart in RUN: restart wins, no lock_lost pulse, lost_cnt unchanged.
  - Lock rising on the timeout cycle in WAIT_LOCK: lock wins, go to STABLE, no retry.
- reset_n asserted mid-sequence: all state returns to reset values immediately, including lost_cnt.
- Never more than one state transition per cycle. pll_bypass and pll_resetb=1 are never both asserted.

Test Plan:
(Bench parameters: PLL_RST_CYCLES=4, LOCK_TIMEOUT=32, STABLE_CYCLES=8, MAX_RETRIES=3.)
1. Normal lock: release reset_n, raise pll_locked 10 cycles later and hold -> pll_resetb high after 4 cycles; sys_ready rises 10 edges after locked is first sampled; state=3; retry_cnt=0.
2. Timeout/fail: pll_locked held 0 -> pll_resetb low 4 cycles every 36 cycles; retry_cnt steps 1,2. At 108 cycles: fail=1, pll_bypass=1, sys_ready=1, state=4, retry_cnt=3.
3. Lock loss: in RUN drop pll_locked for 1 cycle -> 2 edges later sys_ready=0, lock_lost single pulse, lost_cnt=1, state=0. Re-lock returns to RUN. Repeat 20 times -> lost_cnt saturates at 15.
4. Acquisition glitch: in STABLE at counter=5 drop pll_locked 1 cycle -> returns to WAIT_LOCK, retry_cnt unchanged; ready needs a fresh 8 stable cycles.
5. Restart: pulse restart in FAIL, and separately in RUN on the same cycle lock_s falls -> state=0, fail=0, pll_bypass=0, sys_ready=0; no lock_lost pulse, lost_cnt unchanged.
6. Async reset mid-WAIT_LOCK (no clock edge) -> outputs at reset values immediately; lost_cnt=0.
